// File: rtl/mul_rs_dispatch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mul_rs_dispatch                                                        |
// | Mul/div reservation station with CDB snoop and registered dispatch.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module mul_rs_dispatch #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int FUN_W  = 3
) (
  input  logic                         clk1,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         iss_valid,
  output logic                         iss_ready,
  input  logic [FUN_W-1:0]             iss_fun3,
  input  logic [TAG_W-1:0]             iss_des,
  input  logic [DATA_W-1:0]            iss_v1,
  input  logic                         iss_r1,
  input  logic [TAG_W-1:0]             iss_t1,
  input  logic [DATA_W-1:0]            iss_v2,
  input  logic                         iss_r2,
  input  logic [TAG_W-1:0]             iss_t2,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [DATA_W-1:0]            disp_data1,
  output logic [DATA_W-1:0]            disp_data2,
  output logic [TAG_W-1:0]             disp_des,
  output logic [FUN_W-1:0]             disp_fun3,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_IDX_W = $clog2(DEPTH);
  localparam int C_AGE_W = $clog2(DEPTH);
  localparam logic [C_AGE_W-1:0] C_AGE_MAX = C_AGE_W'(DEPTH - 1);

  logic [DEPTH-1:0]   r_vld;
  logic [DEPTH-1:0]   r_r1;
  logic [DEPTH-1:0]   r_r2;
  logic [DATA_W-1:0]  r_v1  [DEPTH];
  logic [DATA_W-1:0]  r_v2  [DEPTH];
  logic [TAG_W-1:0]   r_t1  [DEPTH];
  logic [TAG_W-1:0]   r_t2  [DEPTH];
  logic [TAG_W-1:0]   r_des [DEPTH];
  logic [FUN_W-1:0]   r_fun [DEPTH];
  logic [C_AGE_W-1:0] r_age [DEPTH];
  logic [C_CNT_W-1:0] r_count;

  logic               r_disp_valid;
  logic [DATA_W-1:0]  r_disp_data1;
  logic [DATA_W-1:0]  r_disp_data2;
  logic [TAG_W-1:0]   r_disp_des;
  logic [FUN_W-1:0]   r_disp_fun3;

  logic               w_sel_found;
  logic [C_IDX_W-1:0] w_sel_idx;
  logic [C_AGE_W-1:0] w_sel_age;
  logic [C_IDX_W-1:0] w_free_idx;
  logic               w_iss_fire;
  logic               w_load_ok;
  logic               w_load;
  logic               w_byp1;
  logic               w_byp2;

  // Oldest ready entry; strict '>' keeps the lowest index on equal ages.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_r1[i] && r_r2[i] && (!w_sel_found || (r_age[i] > w_sel_age))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = C_IDX_W'(i);
        w_sel_age   = r_age[i];
      end
    end
  end

  // Lowest-index free slot, from registered valid bits only.
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_vld[i]) w_free_idx = C_IDX_W'(i);
    end
  end

  assign iss_ready  = (r_count < C_CNT_W'(DEPTH));
  assign w_iss_fire = iss_valid && iss_ready;
  assign w_load_ok  = !r_disp_valid || disp_ready;
  assign w_load     = w_load_ok && w_sel_found;
  assign w_byp1     = cdb_valid && !iss_r1 && (iss_t1 == cdb_tag);
  assign w_byp2     = cdb_valid && !iss_r2 && (iss_t2 == cdb_tag);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_vld        <= '0;
      r_r1         <= '0;
      r_r2         <= '0;
      r_count      <= '0;
      r_disp_valid <= 1'b0;
      r_disp_data1 <= '0;
      r_disp_data2 <= '0;
      r_disp_des   <= '0;
      r_disp_fun3  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_v1[i]  <= '0;
        r_v2[i]  <= '0;
        r_t1[i]  <= '0;
        r_t2[i]  <= '0;
        r_des[i] <= '0;
        r_fun[i] <= '0;
        r_age[i] <= '0;
      end
    end else if (flush) begin
      r_vld        <= '0;
      r_count      <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_vld[i] && !r_r1[i] && (r_t1[i] == cdb_tag)) begin
            r_v1[i] <= cdb_data;
            r_r1[i] <= 1'b1;
          end
          if (r_vld[i] && !r_r2[i] && (r_t2[i] == cdb_tag)) begin
            r_v2[i] <= cdb_data;
            r_r2[i] <= 1'b1;
          end
        end
      end

      if (w_load_ok) begin
        r_disp_valid <= w_sel_found;
        if (w_sel_found) begin
          r_disp_data1     <= r_v1[w_sel_idx];
          r_disp_data2     <= r_v2[w_sel_idx];
          r_disp_des       <= r_des[w_sel_idx];
          r_disp_fun3      <= r_fun[w_sel_idx];
          r_vld[w_sel_idx] <= 1'b0;
        end
      end

      // The free slot was invalid this cycle, so it never collides with the load.
      if (w_iss_fire) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_vld[i] && (r_age[i] != C_AGE_MAX)) r_age[i] <= r_age[i] + C_AGE_W'(1);
        end
        r_vld[w_free_idx] <= 1'b1;
        r_fun[w_free_idx] <= iss_fun3;
        r_des[w_free_idx] <= iss_des;
        r_age[w_free_idx] <= '0;
        r_t1[w_free_idx]  <= iss_t1;
        r_t2[w_free_idx]  <= iss_t2;
        r_r1[w_free_idx]  <= iss_r1 || w_byp1;
        r_r2[w_free_idx]  <= iss_r2 || w_byp2;
        r_v1[w_free_idx]  <= w_byp1 ? cdb_data : iss_v1;
        r_v2[w_free_idx]  <= w_byp2 ? cdb_data : iss_v2;
      end

      r_count <= r_count + C_CNT_W'(w_iss_fire) - C_CNT_W'(w_load);
    end
  end

  assign disp_valid = r_disp_valid;
  assign disp_data1 = r_disp_data1;
  assign disp_data2 = r_disp_data2;
  assign disp_des   = r_disp_des;
  assign disp_fun3  = r_disp_fun3;
  assign count      = r_count;

endmodule
`default_nettype wire
